// File: rtl/map_pkg.sv
// Shared constants and FSM state type for the map write arbiter.
package map_pkg;
    localparam int CELLS     = 256;
    localparam int STATE_W   = 5;
    localparam int ADDR_W    = 8;
    localparam int NUM_REQ   = 3;
    localparam int BAND      = 20;
    localparam int NUM_BANDS = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } map_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: grants the first requester at or after the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = map_pkg::NUM_REQ,
    parameter int PTR_W   = map_pkg::ptr_width(map_pkg::NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);
    import map_pkg::*;

    logic found;

    // Outer loop is the distance from the pointer, so the nearest valid request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && req[k] && (((int'(pointer) + i) % NUM_REQ) == k)) begin
                    grant[k]  = 1'b1;
                    grant_idx = PTR_W'(k);
                    found     = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/map_write_arbiter.sv
// Map write port arbiter: banded map initialisation followed by round-robin
// arbitration of requester writes, one registered write per cycle.
module map_write_arbiter #(
    parameter int NUM_REQ = map_pkg::NUM_REQ,
    parameter int CELLS   = map_pkg::CELLS,
    parameter int STATE_W = map_pkg::STATE_W,
    parameter int BAND    = map_pkg::BAND
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     init_start,
    output logic                                     init_busy,
    output logic                                     init_done,
    input  logic [NUM_REQ-1:0]                       req_valid,
    input  logic [NUM_REQ-1:0][map_pkg::ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][STATE_W-1:0]          req_data,
    output logic [NUM_REQ-1:0]                       req_ready,
    output logic                                     wr_en,
    output logic [map_pkg::ADDR_W-1:0]               wr_addr,
    output logic [STATE_W-1:0]                       wr_data
);
    import map_pkg::*;

    localparam int PTR_W  = ptr_width(NUM_REQ);
    localparam int BAND_W = (BAND > 1) ? $clog2(BAND) : 1;
    localparam int BIDX_W = $clog2(NUM_BANDS + 1);

    map_state_t         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [ADDR_W-1:0]  init_addr;
    logic [BAND_W-1:0]  band_cnt;
    logic [BIDX_W-1:0]  band_idx;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic [STATE_W-1:0] init_val;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .PTR_W  (PTR_W)
    ) u_rr (
        .req      (req_valid),
        .pointer  (rr_ptr),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    // A pending re-initialisation takes priority over any requester in the same cycle.
    assign req_ready = ((state == RUN) && !init_start) ? grant : '0;
    assign init_busy = (state == INIT);
    // band_idx saturates at NUM_BANDS, which marks the zero-filled tail of the map.
    assign init_val  = (band_idx < BIDX_W'(NUM_BANDS)) ? STATE_W'(band_idx) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            init_addr <= '0;
            band_cnt  <= '0;
            band_idx  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            init_done <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            init_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_start) begin
                        state     <= INIT;
                        init_addr <= '0;
                        band_cnt  <= '0;
                        band_idx  <= '0;
                    end
                end
                INIT: begin
                    wr_en     <= 1'b1;
                    wr_addr   <= init_addr;
                    wr_data   <= init_val;
                    init_addr <= init_addr + ADDR_W'(1);
                    if (band_cnt == BAND_W'(BAND - 1)) begin
                        band_cnt <= '0;
                        if (band_idx != BIDX_W'(NUM_BANDS)) begin
                            band_idx <= band_idx + BIDX_W'(1);
                        end
                    end else begin
                        band_cnt <= band_cnt + BAND_W'(1);
                    end
                    if (init_addr == ADDR_W'(CELLS - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (init_start) begin
                        state     <= INIT;
                        init_addr <= '0;
                        band_cnt  <= '0;
                        band_idx  <= '0;
                    end else if (|req_ready) begin
                        wr_en   <= 1'b1;
                        wr_addr <= req_addr[grant_idx];
                        wr_data <= req_data[grant_idx];
                        rr_ptr  <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_map_write_arbiter.sv
// Self-checking bench for map_write_arbiter using a behavioural reference model.
module tb_map_write_arbiter;
    import map_pkg::*;

    localparam int N = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                init_start;
    logic                init_busy;
    logic                init_done;
    logic [N-1:0]        req_valid;
    logic [N-1:0][7:0]   req_addr;
    logic [N-1:0][4:0]   req_data;
    logic [N-1:0]        req_ready;
    logic                wr_en;
    logic [7:0]          wr_addr;
    logic [4:0]          wr_data;

    int errors = 0;
    int checks = 0;

    int         m_ptr;
    logic [7:0] m_addr;
    logic [4:0] m_data;

    map_write_arbiter #(
        .NUM_REQ(N),
        .CELLS  (256),
        .STATE_W(5),
        .BAND   (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .init_start(init_start),
        .init_busy (init_busy),
        .init_done (init_done),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    function automatic int model_pick(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [4:0] model_init(input int i);
        if (i < 11 * 20) return 5'(i / 20);
        return 5'd0;
    endfunction

    // Caller has set init_start=1 at posedge+1; covers the whole INIT phase.
    task automatic run_init_sweep(input string tag);
        @(posedge clk); #1;
        init_start = 1'b0;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s first_cycle_wr_en: got %b expected 0", tag, wr_en);
        end
        for (int i = 0; i < 256; i++) begin
            req_valid = N'($urandom);
            req_addr  = {N{8'($urandom)}};
            #1;
            checks++;
            if (req_ready !== '0 || init_busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s init_ready_busy idx %0d: got ready=%b busy=%b expected ready=0 busy=1",
                         tag, i, req_ready, init_busy);
            end
            @(posedge clk); #1;
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 8'(i) || wr_data !== model_init(i)) begin
                errors++;
                $display("[TB] FAIL %s init_write idx %0d: got en=%b addr=%0d data=%0d expected en=1 addr=%0d data=%0d",
                         tag, i, wr_en, wr_addr, wr_data, i, model_init(i));
            end
            checks++;
            if (init_done !== (i == 255)) begin
                errors++;
                $display("[TB] FAIL %s init_done idx %0d: got %b expected %b", tag, i, init_done, (i == 255));
            end
        end
        req_valid = '0;
        checks++;
        if (init_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s busy_after_init: got %b expected 0", tag, init_busy);
        end
        m_addr = 8'd255;
        m_data = model_init(255);
    endtask

    // mode 0: all valid at 5/6/7; mode 1: req0/req2 to addr 9; mode 2: random held requests.
    task automatic run_traffic(input int mode, input int cycles, input string tag);
        logic [N-1:0] exp_ready;
        logic         m_en;
        int           g;
        int           waited [N];
        for (int k = 0; k < N; k++) waited[k] = 0;
        init_start = 1'b0;
        if (mode == 0) begin
            req_valid = '1;
            for (int k = 0; k < N; k++) begin
                req_addr[k] = 8'(5 + k);
                req_data[k] = 5'($urandom);
            end
        end else if (mode == 1) begin
            req_valid   = 3'b101;
            req_addr[0] = 8'd9;
            req_data[0] = 5'd3;
            req_addr[1] = 8'($urandom);
            req_data[1] = 5'($urandom);
            req_addr[2] = 8'd9;
            req_data[2] = 5'd4;
        end else begin
            req_valid = N'($urandom);
            for (int k = 0; k < N; k++) begin
                req_addr[k] = 8'($urandom);
                req_data[k] = 5'($urandom);
            end
        end
        for (int c = 0; c < cycles; c++) begin
            #1;
            g = model_pick(req_valid, m_ptr);
            exp_ready = (g < 0) ? '0 : (N'(1) << g);
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL %s req_ready cyc %0d: got %b expected %b", tag, c, req_ready, exp_ready);
            end
            for (int k = 0; k < N; k++) if (req_valid[k]) waited[k]++;
            if (g >= 0) begin
                checks++;
                if (waited[g] > N) begin
                    errors++;
                    $display("[TB] FAIL %s starvation req %0d: waited %0d expected <= %0d", tag, g, waited[g], N);
                end
                waited[g] = 0;
                m_en   = 1'b1;
                m_addr = req_addr[g];
                m_data = req_data[g];
                m_ptr  = (g + 1) % N;
            end else begin
                m_en = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (wr_en !== m_en || wr_addr !== m_addr || wr_data !== m_data) begin
                errors++;
                $display("[TB] FAIL %s write cyc %0d: got en=%b addr=%0d data=%0d expected en=%b addr=%0d data=%0d",
                         tag, c, wr_en, wr_addr, wr_data, m_en, m_addr, m_data);
            end
            if (g >= 0) begin
                if (mode == 0) req_data[g] = 5'($urandom);
                else req_valid[g] = 1'b0;
            end
            if (mode == 2) begin
                for (int k = 0; k < N; k++) begin
                    if (!req_valid[k] && ($urandom_range(0, 1) == 1)) begin
                        req_valid[k] = 1'b1;
                        req_addr[k]  = 8'($urandom);
                        req_data[k]  = 5'($urandom);
                    end
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        init_start = 1'b0;
        req_valid  = '1;
        req_addr   = {8'd1, 8'd2, 8'd3};
        req_data   = {5'd7, 5'd8, 5'd9};
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 8'd0 || wr_data !== 5'd0 || init_busy !== 1'b0 ||
            init_done !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: got en=%b addr=%0d data=%0d busy=%b done=%b ready=%b expected all 0",
                     wr_en, wr_addr, wr_data, init_busy, init_done, req_ready);
        end
        reset  = 1'b0;
        m_ptr  = 0;
        m_addr = 8'd0;
        m_data = 5'd0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== '0 || init_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_ready cyc %0d: got ready=%b busy=%b expected 0 0", c, req_ready, init_busy);
            end
            @(posedge clk); #1;
            checks++;
            if (wr_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_wr_en cyc %0d: got %b expected 0", c, wr_en);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_init();
        init_start = 1'b1;
        run_init_sweep("init");
    endtask

    task automatic test_round_robin();
        run_traffic(0, 9, "round_robin");
    endtask

    task automatic test_same_addr();
        run_traffic(1, 3, "same_addr");
    endtask

    task automatic test_random();
        run_traffic(2, 150, "random");
    endtask

    task automatic test_init_during_run();
        req_valid   = 3'b010;
        req_addr[1] = 8'd77;
        req_data[1] = 5'd12;
        init_start  = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("[TB] FAIL init_start_blocks_grant: got %b expected 000", req_ready);
        end
        run_init_sweep("reinit");
        run_traffic(2, 60, "random_after_reinit");
    endtask

    task automatic test_reset_mid_init();
        bit found;
        init_start = 1'b1;
        @(posedge clk); #1;
        init_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(posedge clk); #1;
            if (wr_en && wr_addr == 8'd100) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL reach_addr_100: got timeout expected write to addr 100");
        end
        req_valid = '1;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 8'd0 || wr_data !== 5'd0 || init_busy !== 1'b0 ||
            init_done !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("[TB] FAIL mid_init_reset: got en=%b addr=%0d data=%0d busy=%b done=%b ready=%b expected all 0",
                     wr_en, wr_addr, wr_data, init_busy, init_done, req_ready);
        end
        @(posedge clk); #1;
        reset  = 1'b0;
        m_ptr  = 0;
        m_addr = 8'd0;
        m_data = 5'd0;
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++;
            if (req_ready !== '0 || init_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset_idle cyc %0d: got ready=%b busy=%b expected 0 0", c, req_ready, init_busy);
            end
            @(posedge clk); #1;
            checks++;
            if (wr_en !== 1'b0 || wr_addr !== 8'd0 || wr_data !== 5'd0) begin
                errors++;
                $display("[TB] FAIL post_reset_write cyc %0d: got en=%b addr=%0d data=%0d expected 0 0 0",
                         c, wr_en, wr_addr, wr_data);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_pointer_after_reset();
        init_start = 1'b1;
        run_init_sweep("init_after_reset");
        run_traffic(0, 3, "rr_after_reset");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_init();
        test_round_robin();
        test_same_addr();
        test_random();
        test_init_during_run();
        test_reset_mid_init();
        test_pointer_after_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/map_write_arbiter.md
MAP_WRITE_ARBITER -- requirements
Module: map_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of write requesters (index 0 player0, 1 player1, 2 explosion unit).
REQ-002 Parameter CELLS, default 256, number of map cells.
REQ-003 Parameter STATE_W, default 5, bits per cell state.
REQ-004 Parameter BAND, default 20, cells per initialisation band.
REQ-005 Port clk  input  1  clock; all logic on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port init_start  input  1  single-cycle pulse requesting map initialisation.
REQ-008 Port init_busy  output  1  high while the INIT state is active.
REQ-009 Port init_done  output  1  one-cycle pulse after the last init write issues.
REQ-010 Port req_valid  input  NUM_REQ  per-requester write request.
REQ-011 Port req_addr  input  NUM_REQ x 8  per-requester cell index.
REQ-012 Port req_data  input  NUM_REQ x STATE_W  per-requester new cell state.
REQ-013 Port req_ready  output  NUM_REQ  per-requester grant; transfer when valid and ready are both high.
REQ-014 Port wr_en  output  1  map write strobe.
REQ-015 Port wr_addr  output  8  map write index.
REQ-016 Port wr_data  output  STATE_W  map write value.

Function
REQ-017 The FSM SHALL have states IDLE, INIT, RUN; reset enters IDLE.
REQ-018 IDLE SHALL go to INIT on init_start; RUN SHALL go to INIT on init_start; init_start in INIT SHALL be ignored.
REQ-019 INIT SHALL issue one write per cycle, addresses 0..CELLS-1 ascending, CELLS cycles total, then go to RUN.
REQ-020 The init value for cell i SHALL be floor(i/BAND) for i < 11*BAND (220) and 0 otherwise; generated with a band counter, no divider.
REQ-021 init_done SHALL pulse in the cycle after the write to address CELLS-1 and coincide with the first RUN cycle.
REQ-022 req_ready SHALL be all-zero in IDLE and INIT and in any cycle init_start is high.
REQ-023 In RUN, req_ready SHALL be combinational, one-hot or zero, granting the first valid requester at or after the round-robin pointer.
REQ-024 The round-robin pointer SHALL be 0 after reset; after a grant to k it SHALL become (k+1) mod NUM_REQ; unchanged when no grant occurs.
REQ-025 A transfer SHALL produce wr_en=1 with the granted addr/data on the next cycle (latency 1); otherwise wr_en=0.
REQ-026 Requests to the same address in the same cycle SHALL be serialised by round-robin order; the later grant overwrites.
REQ-027 A requester held valid SHALL be granted within NUM_REQ RUN cycles (no starvation).
REQ-028 wr_addr/wr_data SHALL hold their last values while wr_en=0.

Reset
REQ-029 Reset SHALL force state IDLE, wr_en 0, wr_addr 0, wr_data 0, init_busy 0, init_done 0, pointer 0, init counters 0.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL abort immediately; no wr_en pulse SHALL appear after reset is released until a new transfer or init_start.

Structure
REQ-031 Package map_pkg SHALL hold CELLS, STATE_W, ADDR_W=8, NUM_REQ, BAND, NUM_BANDS=11 and the FSM state enum.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (req, pointer in; one-hot grant, grant index out).

Verification
REQ-033 Reset, init_start pulse -> 256 consecutive wr_en cycles; addr 0 data 0, addr 19 data 0, addr 20 data 1, addr 219 data 10, addr 220..255 data 0; init_done one pulse.
REQ-034 RUN, all three valid continuously with addrs 5/6/7 -> grants 0,1,2,0,... each cycle; writes appear one cycle after each grant.
REQ-035 RUN, req0 and req2 valid to addr 9 data 3 and 4 -> wr_addr 9 data 3 then data 4.
REQ-036 RUN, init_start with req1 valid same cycle -> no grant, INIT starts next cycle, req_ready 0 for 256 cycles.
REQ-037 Reset asserted at INIT address 100 -> outputs at reset values, state IDLE, no writes until next init_start.
